video_to_axis_pack: RTL and testbench

Single-clock, parametrised successor to the video-to-AXI-Stream bridge. It packs PPC video pixels per AXI-Stream beat and marks partial line-end beats with tkeep. Beats are buffered in an internal synchronous FIFO. On FIFO overflow it drops the rest of the frame and resynchronises on the next frame start. It sits between a video timing source and a VDMA S2MM port running on the same clock.

---
 rtl/video_axis_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/video_to_axis_pack.sv | 192 +++++++++++++++++++
 tb/tb_video_to_axis_pack.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_axis_pkg.sv
// Shared types and FIFO entry layout for the video-to-AXI-Stream packer.
package video_axis_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } state_t;

  // FIFO entry layout: {tuser, tlast, tkeep, tdata}, with tdata at bit 0.
  function automatic int keep_lsb(input int data_bits, input int ppc);
    return data_bits * ppc;
  endfunction

  function automatic int last_bit(input int data_bits, input int ppc);
    return data_bits * ppc + ppc;
  endfunction

  function automatic int user_bit(input int data_bits, input int ppc);
    return data_bits * ppc + ppc + 1;
  endfunction

  function automatic int entry_bits(input int data_bits, input int ppc);
    return data_bits * ppc + ppc + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO, 2**AW entries of DW bits.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; simultaneous push and pop keep the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/video_to_axis_pack.sv
// Packs PPC video pixels per AXI-Stream beat, buffers beats in a FIFO and
// drops the remainder of a frame after a FIFO overflow.
module video_to_axis_pack
  import video_axis_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PPC       = 2,
  parameter int ADDR_BITS = 4,
  parameter int VSYNC_POL = 1,
  parameter int CNT_BITS  = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     vid_vsync,
  input  logic                     vid_active_video,
  input  logic [DATA_BITS-1:0]     vid_data,
  output logic [PPC*DATA_BITS-1:0] m_axis_tdata,
  output logic [PPC-1:0]           m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  input  logic                     clr_status,
  output logic                     overflow,
  output logic [CNT_BITS-1:0]      dropped_frames,
  output logic [CNT_BITS-1:0]      frame_count
);

  localparam int PD       = PPC * DATA_BITS;
  localparam int EW       = entry_bits(DATA_BITS, PPC);
  localparam int KEEP_LSB = keep_lsb(DATA_BITS, PPC);
  localparam int LAST_BIT = last_bit(DATA_BITS, PPC);
  localparam int USER_BIT = user_bit(DATA_BITS, PPC);
  localparam int IW       = (PPC > 1) ? $clog2(PPC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PPC - 1);

  state_t              state, state_nx;
  logic                vsync_r, active_r;
  logic [DATA_BITS-1:0] data_r;
  logic [PD-1:0]       pack_data, pack_data_nx, beat_data;
  logic [PPC-1:0]      pack_keep, pack_keep_nx, beat_keep;
  logic [IW-1:0]       idx, idx_nx;
  logic                sof_pending, sof_pending_nx;
  logic                sof, line_end, push, pop, lost, drop_inc;
  logic                beat_last, beat_user;
  logic [EW-1:0]       wdata, rdata, rd_gated;
  logic                fifo_full, fifo_empty;
  logic [ADDR_BITS:0]  fifo_count;

  assign sof      = (VSYNC_POL != 0) ? (vid_vsync & ~vsync_r) : (~vid_vsync & vsync_r);
  assign line_end = active_r & ~vid_active_video;
  assign pop      = m_axis_tvalid & m_axis_tready;

  // Input stage: one register level on the raw video timing.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vsync_r  <= 1'b0;
      active_r <= 1'b0;
      data_r   <= '0;
    end else begin
      vsync_r  <= vid_vsync;
      active_r <= vid_active_video;
      data_r   <= vid_data;
    end
  end

  // FSM state and packer registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= WAIT_SOF;
      pack_data   <= '0;
      pack_keep   <= '0;
      idx         <= '0;
      sof_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      pack_data   <= pack_data_nx;
      pack_keep   <= pack_keep_nx;
      idx         <= idx_nx;
      sof_pending <= sof_pending_nx;
    end
  end

  // Next state, beat assembly and push decision.
  always_comb begin
    beat_data = pack_data;
    beat_keep = pack_keep;
    if (active_r) begin
      beat_data[idx*DATA_BITS +: DATA_BITS] = data_r;
      beat_keep[idx] = 1'b1;
    end
    state_nx       = state;
    pack_data_nx   = pack_data;
    pack_keep_nx   = pack_keep;
    idx_nx         = idx;
    sof_pending_nx = sof_pending | sof;
    push           = 1'b0;
    lost           = 1'b0;
    drop_inc       = 1'b0;
    beat_user      = sof_pending;
    // A frame start cuts any partial beat short, so it also closes the line.
    beat_last      = line_end | (sof & (beat_keep != '0));
    case (state)
      WAIT_SOF: begin
        pack_data_nx = '0;
        pack_keep_nx = '0;
        idx_nx       = '0;
        if (sof) state_nx = PASS;
      end
      PASS: begin
        push = (active_r & ((idx == LAST_IDX) | line_end)) | (sof & (beat_keep != '0));
        if (push) begin
          pack_data_nx   = '0;
          pack_keep_nx   = '0;
          idx_nx         = '0;
          // The pushed beat consumed the old flag; a new frame start re-arms it.
          sof_pending_nx = sof;
          if (fifo_full && !pop) begin
            lost     = 1'b1;
            state_nx = DROP;
          end
        end else if (active_r) begin
          pack_data_nx = beat_data;
          pack_keep_nx = beat_keep;
          idx_nx       = idx + 1'b1;
        end
      end
      DROP: begin
        pack_data_nx = '0;
        pack_keep_nx = '0;
        idx_nx       = '0;
        if (sof) begin
          state_nx = PASS;
          drop_inc = 1'b1;
        end
      end
      default: state_nx = WAIT_SOF;
    endcase
  end

  // FIFO entry packing in the shared field layout.
  always_comb begin
    wdata                       = '0;
    wdata[PD-1:0]               = beat_data;
    wdata[KEEP_LSB +: PPC]      = beat_keep;
    wdata[LAST_BIT]             = beat_last;
    wdata[USER_BIT]             = beat_user;
  end

  sync_fifo #(
    .DW (EW),
    .AW (ADDR_BITS)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push & ~lost),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read zero whenever no beat is presented.
  assign m_axis_tvalid = (fifo_count != '0);
  assign rd_gated      = fifo_empty ? '0 : rdata;
  assign m_axis_tdata  = rd_gated[PD-1:0];
  assign m_axis_tkeep  = rd_gated[KEEP_LSB +: PPC];
  assign m_axis_tlast  = rd_gated[LAST_BIT];
  assign m_axis_tuser  = rd_gated[USER_BIT];

  // Status: overflow sticky, saturating drop counter, wrapping frame counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow       <= 1'b0;
      dropped_frames <= '0;
      frame_count    <= '0;
    end else begin
      if (lost)            overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (drop_inc) begin
        if (clr_status)          dropped_frames <= CNT_BITS'(1);
        else if (!(&dropped_frames)) dropped_frames <= dropped_frames + 1'b1;
      end else if (clr_status) begin
        dropped_frames <= '0;
      end
      if (sof) frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_to_axis_pack.sv
// Directed bench for video_to_axis_pack with PPC=2, DATA_BITS=8, ADDR_BITS=4.
module tb_video_to_axis_pack;

  logic        aclk = 1'b0;
  logic        areset;
  logic        vid_vsync;
  logic        vid_active_video;
  logic [7:0]  vid_data;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        clr_status;
  logic        overflow;
  logic [15:0] dropped_frames;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rx_data[$];
  logic [1:0]  rx_keep[$];
  logic        rx_last[$];
  logic        rx_user[$];

  // Clock
  always #5 aclk = ~aclk;

  video_to_axis_pack #(
    .DATA_BITS (8),
    .PPC       (2),
    .ADDR_BITS (4),
    .VSYNC_POL (1),
    .CNT_BITS  (16)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .vid_vsync        (vid_vsync),
    .vid_active_video (vid_active_video),
    .vid_data         (vid_data),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .clr_status       (clr_status),
    .overflow         (overflow),
    .dropped_frames   (dropped_frames),
    .frame_count      (frame_count)
  );

  // Capture every accepted beat, sampled on the falling edge before the pop edge.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_keep.push_back(m_axis_tkeep);
      rx_last.push_back(m_axis_tlast);
      rx_user.push_back(m_axis_tuser);
    end
  end

  // Driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_keep.delete();
    rx_last.delete();
    rx_user.delete();
  endtask

  task automatic vsync_pulse();
    vid_vsync = 1'b1;
    step();
    vid_vsync = 1'b0;
    step();
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      vid_active_video = 1'b1;
      vid_data         = base + 8'(i);
      step();
    end
    vid_active_video = 1'b0;
    vid_data         = 8'h00;
    step(2);
  endtask

  task automatic test_reset();
    areset = 1'b1; vid_vsync = 1'b0; vid_active_video = 1'b0; vid_data = 8'h00;
    m_axis_tready = 1'b1; clr_status = 1'b0;
    step(3);
    areset = 1'b0;
    step();
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_axis got valid=%b data=%h keep=%b last=%b user=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    n_checks++;
    if ({overflow, dropped_frames, frame_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_status got ovf=%b dropped=%0d frames=%0d want 0 0 0",
               overflow, dropped_frames, frame_count);
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] ed [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    logic        el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        eu [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    clear_rx();
    vsync_pulse();
    send_line(8'h01, 4);
    send_line(8'h05, 4);
    step(4);
    n_checks++;
    if (rx_data.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 4", rx_data.size());
    end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== ed[i] || rx_keep[i] !== 2'b11 || rx_last[i] !== el[i] || rx_user[i] !== eu[i]) begin
        n_fail++;
        $display("FAIL basic_beat%0d got data=%h keep=%b last=%b user=%b want data=%h keep=11 last=%b user=%b",
                 i, rx_data[i], rx_keep[i], rx_last[i], rx_user[i], ed[i], el[i], eu[i]);
      end
    end
    n_checks++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_partial_beat();
    logic [15:0] ed [3] = '{16'h1110, 16'h1312, 16'h0014};
    logic [1:0]  ek [3] = '{2'b11, 2'b11, 2'b01};
    logic        el [3] = '{1'b0, 1'b0, 1'b1};
    clear_rx();
    send_line(8'h10, 5);
    step(4);
    n_checks++;
    if (rx_data.size() != 3) begin
      n_fail++;
      $display("FAIL partial_count got %0d want 3", rx_data.size());
    end
    for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== ed[i] || rx_keep[i] !== ek[i] || rx_last[i] !== el[i] || rx_user[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_beat%0d got data=%h keep=%b last=%b user=%b want data=%h keep=%b last=%b user=0",
                 i, rx_data[i], rx_keep[i], rx_last[i], rx_user[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int bad;
    clear_rx();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vid_active_video = 1'b1;
      vid_data         = 8'h40 + 8'(i);
      step();
      if (i == 6) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h4140) begin
          n_fail++;
          $display("FAIL stall_head got valid=%b data=%h want valid=1 data=4140", m_axis_tvalid, m_axis_tdata);
        end
      end
    end
    vid_active_video = 1'b0;
    step(2);
    n_checks++;
    if (m_axis_tdata !== 16'h4140 || m_axis_tkeep !== 2'b11 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold got data=%h keep=%b user=%b last=%b want 4140 11 0 0",
               m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag got %b want 1", overflow);
    end
    m_axis_tready = 1'b1;
    step(20);
    n_checks++;
    if (rx_data.size() != 16) begin
      n_fail++;
      $display("FAIL ovf_drain_count got %0d want 16", rx_data.size());
    end
    bad = 0;
    for (int k = 0; k < 16 && k < rx_data.size(); k++) begin
      if (rx_data[k] !== {8'h41 + 8'(2*k), 8'h40 + 8'(2*k)} || rx_keep[k] !== 2'b11 ||
          rx_last[k] !== 1'b0 || rx_user[k] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ovf_drain_data got %0d wrong beats want 0", bad);
    end
    clear_rx();
    vsync_pulse();
    send_line(8'h80, 4);
    step(4);
    n_checks++;
    if (rx_data.size() != 2) begin
      n_fail++;
      $display("FAIL resync_count got %0d want 2", rx_data.size());
    end else begin
      n_checks++;
      if (rx_data[0] !== 16'h8180 || rx_user[0] !== 1'b1 || rx_last[0] !== 1'b0 ||
          rx_data[1] !== 16'h8382 || rx_user[1] !== 1'b0 || rx_last[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL resync_beats got %h/u%b/l%b %h/u%b/l%b want 8180/u1/l0 8382/u0/l1",
                 rx_data[0], rx_user[0], rx_last[0], rx_data[1], rx_user[1], rx_last[1]);
      end
    end
    n_checks++;
    if (dropped_frames !== 16'd1 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL resync_status got dropped=%0d frames=%0d want 1 2", dropped_frames, frame_count);
    end
  endtask

  task automatic test_reset_mid_line();
    m_axis_tready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      vid_active_video = 1'b1;
      vid_data         = 8'h60 + 8'(i);
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_prefill got valid=%b want 1", m_axis_tvalid);
    end
    areset = 1'b1;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || frame_count !== 16'd0 || dropped_frames !== 16'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_reset got valid=%b frames=%0d dropped=%0d ovf=%b want 0 0 0 0",
               m_axis_tvalid, frame_count, dropped_frames, overflow);
    end
    step();
    areset = 1'b0;
    clear_rx();
    m_axis_tready = 1'b1;
    for (int i = 3; i < 7; i++) begin
      vid_active_video = 1'b1;
      vid_data         = 8'h60 + 8'(i);
      step();
    end
    vid_active_video = 1'b0;
    step(2);
    send_line(8'h50, 4);
    step(4);
    n_checks++;
    if (rx_data.size() != 0 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_sof_output got beats=%0d valid=%b want 0 0", rx_data.size(), m_axis_tvalid);
    end
  endtask

  task automatic test_clr_status();
    m_axis_tready = 1'b0;
    vsync_pulse();
    for (int j = 0; j < 36; j++) begin
      vid_active_video = 1'b1;
      vid_data         = 8'h90 + 8'(j);
      clr_status       = (j == 34);
      step();
    end
    clr_status       = 1'b0;
    vid_active_video = 1'b0;
    step(2);
    n_checks++;
    if (overflow !== 1'b1 || dropped_frames !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_vs_set got ovf=%b dropped=%0d want 1 0", overflow, dropped_frames);
    end
    m_axis_tready = 1'b1;
    step(20);
    clear_rx();
    vsync_pulse();
    n_checks++;
    if (dropped_frames !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_dropped_inc got %0d want 1", dropped_frames);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || dropped_frames !== 16'd0 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL clr_lone got ovf=%b dropped=%0d frames=%0d want 0 0 2", overflow, dropped_frames, frame_count);
    end
  endtask

  task automatic test_sof_flush();
    logic [15:0] ed [3] = '{16'h3231, 16'h0033, 16'h3534};
    logic [1:0]  ek [3] = '{2'b11, 2'b01, 2'b11};
    logic        el [3] = '{1'b0, 1'b1, 1'b1};
    logic        eu [3] = '{1'b1, 1'b0, 1'b1};
    clear_rx();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vid_active_video = 1'b1;
      vid_data         = 8'h31 + 8'(i);
      vid_vsync        = (i >= 3);
      step();
    end
    vid_active_video = 1'b0;
    vid_data         = 8'h00;
    step(2);
    vid_vsync = 1'b0;
    step(4);
    n_checks++;
    if (rx_data.size() != 3) begin
      n_fail++;
      $display("FAIL flush_count got %0d want 3", rx_data.size());
    end
    for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
      n_checks++;
      if (rx_data[i] !== ed[i] || rx_keep[i] !== ek[i] || rx_last[i] !== el[i] || rx_user[i] !== eu[i]) begin
        n_fail++;
        $display("FAIL flush_beat%0d got data=%h keep=%b last=%b user=%b want data=%h keep=%b last=%b user=%b",
                 i, rx_data[i], rx_keep[i], rx_last[i], rx_user[i], ed[i], ek[i], el[i], eu[i]);
      end
    end
    n_checks++;
    if (frame_count !== 16'd3) begin
      n_fail++;
      $display("FAIL flush_frame_count got %0d want 3", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_partial_beat();
    test_overflow();
    test_reset_mid_line();
    test_clr_status();
    test_sof_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
